// File: rtl/rx_correlation_unit_mc.sv
// Multi-channel RX chip correlator: per-channel ternary-weighted accumulation over CHIP_LEN samples.
// Optional output clamping with saturation flags when RX_CORR_SAT_EN is defined (default: wrap, osat=0).

module rx_corr_lane #(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 17,
  parameter int ACC_W    = 21
) (
  input  logic                       crx_clk,
  input  logic                       rrx_rst_n,
  input  logic                       clr,
  input  logic                       step,
  input  logic                       first,
  input  logic                       last,
  input  logic                       commit,
  input  logic                       pos_w,
  input  logic                       neg_w,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [OUT_W-1:0]    result,
  output logic                       sat
);
  logic signed [ACC_W-1:0] acc, sx, term, fin;
  logic        [OUT_W-1:0] red;
  logic                    clip;

  // Widen before negating so the most negative sample negates exactly.
  assign sx   = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
  assign term = pos_w ? sx : (neg_w ? -sx : '0);
  assign fin  = (first ? '0 : acc) + term;

`ifdef RX_CORR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) <<< (OUT_W-1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(longint'(1) <<< (OUT_W-1)));
  always_comb begin
    red  = fin[OUT_W-1:0];
    clip = 1'b0;
    if (fin > MAXV) begin
      red  = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (fin < MINV) begin
      red  = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end
`else
  assign red  = fin[OUT_W-1:0];
  assign clip = 1'b0;
`endif

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      acc    <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      if (clr)       acc <= '0;
      else if (step) acc <= last ? '0 : fin;
      if (commit) begin
        result <= red;
        sat    <= clip;
      end
    end
  end
endmodule

module rx_correlation_unit_mc #(
  parameter int          SAMPLE_W        = 16,
  parameter int          NUM_CH          = 2,
  parameter int          CHIP_LEN        = 10,
  parameter logic [63:0] POS_MASK        = 64'h380,
  parameter logic [63:0] NEG_MASK        = 64'h01C,
  parameter int          SAMPLE_POSITION = 0,
  parameter int          OUT_W           = 17,
  localparam int         PH_W            = $clog2(CHIP_LEN),
  localparam int         ACC_W           = SAMPLE_W + $clog2(CHIP_LEN) + 1
) (
  input  logic                       crx_clk,
  input  logic                       rrx_rst_n,
  input  logic                       erx_en,
  input  logic                       inew_sample_trig,
  input  logic [NUM_CH*SAMPLE_W-1:0] isample_bus,
  input  logic                       iphase_load,
  input  logic [PH_W-1:0]            iphase_value,
  output logic [PH_W-1:0]            ophase,
  output logic                       ochip_valid,
  output logic [NUM_CH*OUT_W-1:0]    oresult_bus,
  output logic [NUM_CH-1:0]          osat
);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CHIP_LEN - 1);

  logic chip_ok;  // current chip has been enabled since its start (or a load/reset)
  logic first, last, step, clr, commit, pos_w, neg_w, load_ok;

  assign first   = (ophase == '0);
  assign last    = (ophase == PH_LAST);
  assign step    = inew_sample_trig & erx_en & ~iphase_load;
  assign clr     = iphase_load | ~erx_en;
  assign commit  = step & last & chip_ok;
  assign pos_w   = POS_MASK[ophase] & ~NEG_MASK[ophase];
  assign neg_w   = NEG_MASK[ophase] & ~POS_MASK[ophase];
  assign load_ok = 32'(iphase_value) < 32'(CHIP_LEN);

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      ophase      <= PH_W'(SAMPLE_POSITION);
      chip_ok     <= 1'b1;
      ochip_valid <= 1'b0;
    end else begin
      ochip_valid <= commit;
      if (iphase_load) begin
        ophase  <= load_ok ? iphase_value : '0;
        chip_ok <= 1'b1;
      end else begin
        if (inew_sample_trig) ophase <= last ? '0 : ophase + 1'b1;
        if (!erx_en)                          chip_ok <= 1'b0;
        else if (inew_sample_trig && first)   chip_ok <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    rx_corr_lane #(.SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_lane (
      .crx_clk  (crx_clk),
      .rrx_rst_n(rrx_rst_n),
      .clr      (clr),
      .step     (step),
      .first    (first),
      .last     (last),
      .commit   (commit),
      .pos_w    (pos_w),
      .neg_w    (neg_w),
      .sample   (isample_bus[c*SAMPLE_W +: SAMPLE_W]),
      .result   (oresult_bus[c*OUT_W +: OUT_W]),
      .sat      (osat[c])
    );
  end
endmodule

// File: tb/tb_rx_correlation_unit_mc.sv
// Randomized + directed bench for rx_correlation_unit_mc with a sum-of-products chip model and result scoreboard.
module tb_rx_correlation_unit_mc;
  localparam int SW = 16, NCH = 2, CL = 10, OW = 17, PHW = 4;
  localparam logic [63:0] POS = 64'h380, NEG = 64'h01C;
  localparam longint MAXL = (longint'(1) <<< (OW-1)) - 1;
  localparam longint MINL = -(longint'(1) <<< (OW-1));

  logic crx_clk = 1'b0, rrx_rst_n = 1'b0, erx_en = 1'b1, trig = 1'b0, ld = 1'b0;
  logic [NCH*SW-1:0] sbus = '0;
  logic [PHW-1:0]    pval = '0;
  logic [PHW-1:0]    ophase, ophase3;
  logic              valid, valid3;
  logic [NCH*OW-1:0] res, res3;
  logic [NCH-1:0]    sat, sat3;

  rx_correlation_unit_mc dut (
    .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en), .inew_sample_trig(trig),
    .isample_bus(sbus), .iphase_load(ld), .iphase_value(pval), .ophase(ophase),
    .ochip_valid(valid), .oresult_bus(res), .osat(sat));

  rx_correlation_unit_mc #(.SAMPLE_POSITION(3)) dut3 (
    .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en), .inew_sample_trig(trig),
    .isample_bus(sbus), .iphase_load(ld), .iphase_value(pval), .ophase(ophase3),
    .ochip_valid(valid3), .oresult_bus(res3), .osat(sat3));

  always #5 crx_clk = ~crx_clk;

  typedef struct { logic [NCH*OW-1:0] res; logic [NCH-1:0] sat; int due; } exp_t;
  exp_t q[$];

  int errs = 0, checks = 0, cyc = 0, trig_cnt = 0;
  int ph = 0;
  bit ok = 1'b1, seen3 = 1'b0;
  longint smp [NCH][CL];
  logic [NCH*OW-1:0] hold_res = '0;
  logic [NCH-1:0]    hold_sat = '0;

  always @(posedge crx_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int p);
    if (POS[p] && !NEG[p]) return 1;
    if (NEG[p] && !POS[p]) return -1;
    return 0;
  endfunction

  task automatic clear_chip();
    for (int c = 0; c < NCH; c++) for (int p = 0; p < CL; p++) smp[c][p] = 0;
  endtask

  task automatic push_expected();
    exp_t e;
    longint f;
    logic [OW-1:0] r;
    logic s;
    for (int c = 0; c < NCH; c++) begin
      f = 0;
      for (int p = 0; p < CL; p++) f += wt(p) * smp[c][p];
`ifdef RX_CORR_SAT_EN
      s = 1'b1;
      if (f > MAXL)      r = OW'(MAXL);
      else if (f < MINL) r = OW'(MINL);
      else begin r = OW'(f); s = 1'b0; end
`else
      r = OW'(f);
      s = 1'b0;
`endif
      e.res[c*OW +: OW] = r;
      e.sat[c] = s;
    end
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every valid pops one expected chip; otherwise outputs must hold.
  always @(negedge crx_clk) begin
    if (valid) begin
      if (q.size() == 0) chk("unexpected_valid", 64'(res), 64'hDEAD);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 64'(res), 64'(e.res));
        chk("sat", 64'(sat), 64'(e.sat));
        chk("valid_cycle", 64'(cyc), 64'(e.due));
        hold_res = e.res;
        hold_sat = e.sat;
      end
    end else begin
      chk("result_hold", 64'(res), 64'(hold_res));
      chk("sat_hold", 64'(sat), 64'(hold_sat));
    end
  end

  task automatic step(input bit t, input bit en, input bit l, input int pv,
                      input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    logic [SW-1:0] sv [NCH];
    @(negedge crx_clk);
    trig = t; erx_en = en; ld = l; pval = PHW'(pv); sbus = {s1, s0};
    sv[0] = s0; sv[1] = s1;
    if (t) trig_cnt++;
    if (l) begin
      ph = (pv >= CL) ? 0 : pv;
      ok = 1'b1;
      clear_chip();
    end else begin
      if (!en) begin ok = 1'b0; clear_chip(); end
      if (t) begin
        if (en) begin
          if (ph == 0) begin ok = 1'b1; clear_chip(); end
          for (int c = 0; c < NCH; c++) smp[c][ph] = longint'($signed(sv[c]));
          if (ph == CL-1 && ok) push_expected();
        end
        ph = (ph + 1) % CL;
      end
    end
    @(posedge crx_clk);
    #1;
    chk("phase", 64'(ophase), 64'(ph));
    if (valid3 && !seen3) begin
      chk("first_valid_sp3", 64'(trig_cnt), 64'd7);
      seen3 = 1'b1;
    end
  endtask

  task automatic chip_const(input int n, input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, s0, s1);
  endtask

  initial begin
    clear_chip();
    repeat (2) @(negedge crx_clk);
    chk("rst_phase", 64'(ophase), 64'd0);
    chk("rst_phase_sp3", 64'(ophase3), 64'd3);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    rrx_rst_n = 1'b1;

    // 1: constant 100 on ch0 -> -300+300 = 0
    chip_const(10, 16'd100, 16'd0);
    // 2: ch1 = 1000 on phases 7..9, three chips -> 3000 each
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < CL; p++) step(1, 1, 0, 0, 16'd5, (p >= 7) ? 16'd1000 : 16'd0);
    // 3: extremes -> wrap or clamp
    for (int p = 0; p < CL; p++) begin
      logic [SW-1:0] v;
      v = (p >= 2 && p <= 4) ? 16'h8000 : ((p >= 7) ? 16'h7FFF : 16'h0);
      step(1, 1, 0, 0, v, v);
    end
    // 4: phase load mid-chip, then out-of-range load
    chip_const(4, 16'd77, 16'd77);
    step(1, 1, 1, 7, 16'd10, 16'd10);
    chip_const(3, 16'd10, 16'd10);
    step(0, 1, 1, 12, 16'd0, 16'd0);
    // 5: enable drop at phase 5 kills the chip; next chip is clean
    chip_const(5, 16'd300, 16'd400);
    step(1, 0, 0, 0, 16'd300, 16'd400);
    step(1, 0, 0, 0, 16'd300, 16'd400);
    chip_const(3, 16'd300, 16'd400);
    for (int p = 0; p < CL; p++) step(1, 1, 0, 0, 16'(p * 11), 16'(-p * 7));
    // 6: async reset mid-cycle at phase 6
    chip_const(6, 16'd50, 16'd60);
    @(posedge crx_clk);
    #2 rrx_rst_n = 1'b0;
    trig = 1'b0; ld = 1'b0; erx_en = 1'b1;
    #1;
    chk("arst_phase", 64'(ophase), 64'd0);
    chk("arst_phase_sp3", 64'(ophase3), 64'd3);
    chk("arst_result", 64'(res), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_sat", 64'(sat), 64'd0);
    q.delete();
    hold_res = '0; hold_sat = '0;
    ph = 0; ok = 1'b1; clear_chip();
    @(negedge crx_clk);
    rrx_rst_n = 1'b1;

    // Random traffic including extremes, enable drops and loads
    for (int i = 0; i < 600; i++) begin
      logic [SW-1:0] a, b;
      a = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) != 0) ? 16'h8000 : 16'h7FFF) : SW'($urandom);
      b = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) != 0) ? 16'h8000 : 16'h7FFF) : SW'($urandom);
      step($urandom_range(3, 0) != 0, $urandom_range(15, 0) != 0, $urandom_range(39, 0) == 0,
           int'($urandom_range(15, 0)), a, b);
    end
    step(0, 1, 0, 0, 16'd0, 16'd0);
    step(0, 1, 0, 0, 16'd0, 16'd0);
    chk("pending_expected", 64'(q.size()), 64'd0);
    chk("sp3_valid_seen", 64'(seen3), 64'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rx_correlation_unit_mc.md
Name: rx_correlation_unit_mc

Overview:
Parametrised multi-channel chip correlator for the RX path.
- Accumulates NUM_CH parallel sample streams against a programmable ternary chip template (+1 / -1 / 0 per sample phase) over CHIP_LEN samples.
- Emits one signed result per channel per chip, with a one-cycle valid pulse.
- Sits between the RX sample filter and the PRBS bit-decision logic.
- Supports a runtime phase reload for resynchronisation.

Parameters:
SAMPLE_W, 16, input sample width (signed two's complement)
NUM_CH, 2, number of parallel channels (lags)
CHIP_LEN, 10, samples per chip (2..64)
POS_MASK, 64'h380, bit i set -> weight +1 at phase i (default phases 7,8,9)
NEG_MASK, 64'h01C, bit i set -> weight -1 at phase i (default phases 2,3,4)
SAMPLE_POSITION, 0, phase counter value after reset
OUT_W, 17, output result width per channel
(localparam PH_W = clog2(CHIP_LEN); ACC_W = SAMPLE_W + clog2(CHIP_LEN) + 1)

Ports:
crx_clk  in  1  clock
rrx_rst_n  in  1  asynchronous active-low reset
erx_en  in  1  enable
inew_sample_trig  in  1  new sample strobe, at most 1 per cycle
isample_bus  in  NUM_CH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W]
iphase_load  in  1  force phase counter to iphase_value
iphase_value  in  PH_W  phase to load
ophase  out  PH_W  current phase counter
ochip_valid  out  1  one-cycle pulse, results updated
oresult_bus  out  NUM_CH*OUT_W  per-channel chip correlation result
osat  out  NUM_CH  per-channel saturation flag, qualified by ochip_valid

Behaviour:
Reset (rrx_rst_n=0, asynchronous, immediate):
- ophase = SAMPLE_POSITION.
- Accumulators = 0, oresult_bus = 0, ochip_valid = 0, osat = 0.

Phase counter:
- Advances on inew_sample_trig, from CHIP_LEN-1 wrapping to 0.
- Counts regardless of erx_en.
- iphase_load has priority over a simultaneous trig: ophase <= iphase_value; values >= CHIP_LEN load 0.
- Load also clears all accumulators; no ochip_valid results from the load cycle.

Weight at phase p:
- +1 if POS_MASK[p] set; -1 if NEG_MASK[p] set; 0 otherwise.
- Both bits set is illegal; RTL treats it as 0.

Accumulation, on trig with erx_en=1, per channel, with t = w*sample sign-extended to ACC_W:
- p==0: acc <= t (fresh chip start).
- 0<p<CHIP_LEN-1: acc <= acc + t.
- p==CHIP_LEN-1: final = acc + t; oresult <= final reduced to OUT_W (see Optional Feature); acc <= 0; ochip_valid=1 on the next cycle only.
- Latency: result and valid are visible 1 cycle after the final-phase trig.
- -(-2^(SAMPLE_W-1)) must be exact: negation is done in ACC_W.

erx_en=0:
- Accumulators forced to 0 each cycle; ochip_valid=0.
- oresult_bus and osat hold their last values.
- A chip interrupted by erx_en low yields no valid; the next full chip after re-enable starts clean at phase 0.

Without a trig:
- No state change except the erx_en clear and the ochip_valid deassert.

Optional Feature:
Macro RX_CORR_SAT_EN.
- Defined: final is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. osat[c]=1 when channel c clamped, updated with oresult; otherwise 0.
- Undefined: oresult = low OUT_W bits of final (two's-complement wrap); osat tied to 0.

Test Plan:
1. Reset, ch0 constant 100, 10 trigs from phase 0 -> one ochip_valid pulse 1 cycle after 10th trig, ch0 result 0 (-300+300).
2. ch1 = 1000 at phases 7..9, 0 elsewhere -> ch1 result 3000. Repeat for 3 chips -> exactly 3 valid pulses, spaced 10 trigs apart.
3. Phases 2..4 = -32768, phases 7..9 = 32767, both channels -> with RX_CORR_SAT_EN: 65535, osat=2'b11. Without: 65533, osat=0.
4. After 4 trigs assert iphase_load with value 7 together with a trig -> ophase=7, acc cleared. Then 3 trigs of 10 -> result 30. iphase_value=12 -> ophase=0.
5. erx_en low for 2 cycles at phase 5 -> no valid for that chip, oresult unchanged, ophase keeps counting. Next full chip gives correct results.
6. Async reset pulse mid-cycle at phase 6 -> outputs 0 without a clock edge, ophase=SAMPLE_POSITION. Repeat with SAMPLE_POSITION=3: first valid after 7 trigs.
